// File: rtl/ram_access_ctrl_if.sv
// Request/response bundle between a CPU/LSU stage (master) and ram_access_ctrl (slave).
interface ram_access_ctrl_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned MW = WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic [MW-1:0]         req_mask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [WIDTH-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Initiator-side Ram controller: one outstanding request, registered re/we strobes, in-order responses.
// Optional MEM_RMW_EN: byte-masked writes via read-modify-write; zero mask completes without a Ram access.
module ram_access_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res,
  ram_access_ctrl_if.slave      bus,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);
  localparam int unsigned MW = WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, RESP
`ifdef MEM_RMW_EN
    , RMW_RD, RMW_CAP
`endif
  } state_t;

  state_t                state, state_d;
  logic                  cur_write, cur_write_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  re_d, we_d;
  logic [ADDR_WIDTH-1:0] raddr_d, waddr_d;
  logic [WIDTH-1:0]      wdata_d;

`ifdef MEM_RMW_EN
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_d;
  logic [WIDTH-1:0]      cur_wdata, cur_wdata_d;
  logic [MW-1:0]         cur_mask, cur_mask_d;
  logic [WIDTH-1:0]      merged;

  // Masked bytes come from the request, the rest from the word just read.
  always_comb begin
    merged = ram_rdata;
    for (int unsigned i = 0; i < MW; i++) begin
      if (cur_mask[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^bus.req_mask;
`endif

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state          <= IDLE;
      cur_write      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      ram_re         <= 1'b0;
      ram_we         <= 1'b0;
      ram_read_addr  <= '0;
      ram_write_addr <= '0;
      ram_wdata      <= '0;
`ifdef MEM_RMW_EN
      cur_addr       <= '0;
      cur_wdata      <= '0;
      cur_mask       <= '0;
`endif
    end else begin
      state          <= state_d;
      cur_write      <= cur_write_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      ram_re         <= re_d;
      ram_we         <= we_d;
      ram_read_addr  <= raddr_d;
      ram_write_addr <= waddr_d;
      ram_wdata      <= wdata_d;
`ifdef MEM_RMW_EN
      cur_addr       <= cur_addr_d;
      cur_wdata      <= cur_wdata_d;
      cur_mask       <= cur_mask_d;
`endif
    end
  end

  // Strobes are decided one state early so they are registered and land in the target state's cycle.
  always_comb begin
    state_d     = state;
    cur_write_d = cur_write;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
    raddr_d     = ram_read_addr;
    waddr_d     = ram_write_addr;
    wdata_d     = ram_wdata;
`ifdef MEM_RMW_EN
    cur_addr_d  = cur_addr;
    cur_wdata_d = cur_wdata;
    cur_mask_d  = cur_mask;
`endif
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cur_write_d = bus.req_write;
`ifdef MEM_RMW_EN
          cur_addr_d  = bus.req_addr;
          cur_wdata_d = bus.req_wdata;
          cur_mask_d  = bus.req_mask;
`endif
          if (!bus.req_write) begin
            state_d = ISSUE;
            re_d    = 1'b1;
            raddr_d = bus.req_addr;
          end
`ifdef MEM_RMW_EN
          else if (bus.req_mask == '0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
          end else if (bus.req_mask != '1) begin
            state_d = RMW_RD;
            re_d    = 1'b1;
            raddr_d = bus.req_addr;
          end
`endif
          else begin
            state_d = ISSUE;
            we_d    = 1'b1;
            waddr_d = bus.req_addr;
            wdata_d = bus.req_wdata;
          end
        end
      end
      ISSUE: begin
        if (cur_write) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        rsp_rdata_d = ram_rdata;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
`ifdef MEM_RMW_EN
      RMW_RD: state_d = RMW_CAP;
      RMW_CAP: begin
        state_d = ISSUE;
        we_d    = 1'b1;
        waddr_d = cur_addr;
        wdata_d = merged;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: attached Ram model, directed scenarios plus random traffic against a word-level memory model.
// Build with +define+MEM_RMW_EN to exercise masked writes.
module tb_ram_access_ctrl;
  logic        clk;
  logic        res;
  logic        ram_re, ram_we;
  logic [7:0]  ram_read_addr, ram_write_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        init_n;

  ram_access_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

  ram_access_ctrl #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .res(res), .bus(bus),
    .ram_re(ram_re), .ram_we(ram_we),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // Attached Ram: registered read port, write has priority.
  logic [31:0] ram_mem [256];
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(8'(i));
      ram_rdata <= '0;
    end else if (ram_we) begin
      ram_mem[ram_write_addr] <= ram_wdata;
    end else if (ram_re) begin
      ram_rdata <= ram_mem[ram_read_addr];
    end
  end

  // Strobe monitor.
  int re_cnt, we_cnt, both_cnt, long_cnt, rst_strobe, cyc;
  int re_cyc[$];
  logic prev_re, prev_we;
  initial begin
    re_cnt = 0; we_cnt = 0; both_cnt = 0; long_cnt = 0; rst_strobe = 0; cyc = 0;
    prev_re = 1'b0; prev_we = 1'b0;
  end
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_re) begin re_cnt = re_cnt + 1; re_cyc.push_back(cyc); end
    if (ram_we) we_cnt = we_cnt + 1;
    if (ram_re && ram_we) both_cnt = both_cnt + 1;
    if ((ram_re && prev_re) || (ram_we && prev_we)) long_cnt = long_cnt + 1;
    if (!res && (ram_re || ram_we)) rst_strobe = rst_strobe + 1;
    prev_re = ram_re;
    prev_we = ram_we;
  end

  int passed = 0, failed = 0, total = 0;
  logic [31:0] ref_mem [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One complete transaction, expectations derived from the memory model and the latency rules.
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] m, input int hold, output logic [31:0] rdata);
    int lat, re0, we0, exp_lat, exp_re, exp_we;
    logic [3:0]  eff_m;
    logic [31:0] exp_rd;
    eff_m   = RMW ? m : 4'hF;
    exp_rd  = wr ? 32'h0 : ref_mem[a];
    exp_lat = wr ? 2 : 3;
    exp_re  = wr ? 0 : 1;
    exp_we  = wr ? 1 : 0;
    if (wr && eff_m == 4'h0) begin exp_lat = 1; exp_we = 0; end
    else if (wr && eff_m != 4'hF) begin exp_lat = 4; exp_re = 1; end
    if (wr) ref_mem[a] = merge(ref_mem[a], d, eff_m);
    re0 = re_cnt;
    we0 = we_cnt;
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_wdata = d;    bus.req_mask = m;   bus.rsp_ready = (hold == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("rsp_write", 64'(bus.rsp_write), 64'(wr));
    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    rdata = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", 64'({bus.rsp_valid, bus.req_ready}), 64'b01);
    check("re_pulses", 64'(re_cnt - re0), 64'(exp_re));
    check("we_pulses", 64'(we_cnt - we0), 64'(exp_we));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n0, re0;
    logic        w;
    logic [7:0]  a;
    logic [3:0]  m;

    init_n = 1'b1;
    res = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_mask = '0;    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    #1 init_n = 1'b0;
    #1 init_n = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_state", 64'({bus.req_ready, ram_re, ram_we, bus.rsp_valid, bus.rsp_write}), 64'b10000);
    check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_ram_bus", 64'({ram_read_addr, ram_write_addr, ram_wdata}), 64'd0);
    res = 1'b1;
    @(negedge clk);

    // Write then read back the same word.
    do_req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    do_req(1'b0, 8'h10, 32'h0, 4'h0, 0, rd);
    check("wr_rd_deadbeef", 64'(rd), 64'hDEADBEEF);

    // Response back-pressure.
    do_req(1'b0, 8'h33, 32'h0, 4'h0, 5, rd);

    // Four back-to-back reads: one strobe every 4 cycles.
    n0 = re_cyc.size();
    for (int k = 0; k < 4; k++) do_req(1'b0, 8'(8'h40 + k), 32'h0, 4'h0, 0, rd);
    check("b2b_re_count", 64'(re_cyc.size() - n0), 64'd4);
    for (int k = 1; k < 4; k++) check("b2b_spacing", 64'(re_cyc[n0 + k] - re_cyc[n0 + k - 1]), 64'd4);

    // Masked writes.
    do_req(1'b1, 8'h20, 32'h11223344, 4'hF, 0, rd);
    do_req(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
    do_req(1'b0, 8'h20, 32'h0, 4'h0, 0, rd);
`ifdef MEM_RMW_EN
    check("rmw_merge", 64'(rd), 64'h11BB33DD);
    do_req(1'b1, 8'h21, 32'h12345678, 4'h0, 0, rd);
    do_req(1'b0, 8'h21, 32'h0, 4'h0, 0, rd);
    check("zero_mask_untouched", 64'(rd), 64'(init_word(8'h21)));
`else
    check("mask_ignored", 64'(rd), 64'hAABBCCDD);
`endif

    // Reset in the middle of a read.
    re0 = re_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_read_re", 64'(ram_re), 64'd1);
    #2 res = 1'b0;
    #1;
    check("mid_rst_strobes", 64'({ram_re, ram_we, bus.rsp_valid}), 64'd0);
    check("mid_rst_raddr", 64'(ram_read_addr), 64'd0);
    repeat (3) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'({bus.req_ready, bus.rsp_valid}), 64'b10);
    repeat (4) @(negedge clk);
    check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("post_rst_re_count", 64'(re_cnt - re0), 64'd1);

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       m = 4'hF;
        1:       m = 4'h0;
        default: m = 4'($urandom);
      endcase
      do_req(w, a, $urandom, m, $urandom_range(0, 2), rd);
    end

    check("re_we_overlap", 64'(both_cnt), 64'd0);
    check("strobe_width", 64'(long_cnt), 64'd0);
    check("strobe_in_reset", 64'(rst_strobe), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
